// File: rtl/card_shoe_arbiter_pkg.sv
// card_shoe_arbiter_pkg: shared rank constants, owner/state types and shoe refill helpers
package card_shoe_arbiter_pkg;
    localparam int RANK_ACE       = 1;
    localparam int RANK_TEN       = 10;
    localparam int CARDS_PER_RANK = 4;
    localparam int TENS_PER_DECK  = 16;

    typedef enum logic {OWN_PLAYER, OWN_DEALER} owner_e;
    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_DELIVER} shoe_state_e;

    function automatic logic [7:0] full_count(input int rank, input int decks);
        return 8'((rank == RANK_TEN ? TENS_PER_DECK : CARDS_PER_RANK) * decks);
    endfunction
endpackage

// File: rtl/card_shoe_arbiter_if.sv
// card_shoe_arbiter_if: draw handshake, RNG feed and shoe status between requesters and the shoe
interface card_shoe_arbiter_if;
    logic [3:0] rng_value;
    logic       p_req;
    logic       d_req;
    logic       shuffle;
    logic       p_ack;
    logic       d_ack;
    logic [3:0] card_out;
    logic [8:0] cards_left;
    logic       shoe_empty;
    logic       busy;

    modport master (
        output rng_value, p_req, d_req, shuffle,
        input  p_ack, d_ack, card_out, cards_left, shoe_empty, busy
    );
    modport slave (
        input  rng_value, p_req, d_req, shuffle,
        output p_ack, d_ack, card_out, cards_left, shoe_empty, busy
    );
endinterface

// File: rtl/card_shoe_arbiter_rank_pool.sv
// card_shoe_arbiter_rank_pool: per-rank card counts with refill, decrement, hit lookup and fallback pick
module card_shoe_arbiter_rank_pool
    import card_shoe_arbiter_pkg::*;
#(
    parameter int NUM_DECKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refill,
    input  logic       dec,
    input  logic [3:0] dec_rank,
    input  logic [3:0] query_rank,
    output logic       query_hit,
    output logic [3:0] lowest_rank,
    output logic [8:0] total
);
    logic [7:0] cnt [RANK_ACE:RANK_TEN];

    // refill every rank on reset or shuffle, otherwise remove the drawn card
    always_ff @(posedge clk) begin
        if (rst || refill) begin
            for (int r = RANK_ACE; r <= RANK_TEN; r++) cnt[r] <= full_count(r, NUM_DECKS);
        end else if (dec) begin
            for (int r = RANK_ACE; r <= RANK_TEN; r++)
                if (dec_rank == 4'(r) && cnt[r] != 8'd0) cnt[r] <= cnt[r] - 8'd1;
        end
    end

    // hit test for the sampled rank, lowest non-empty rank, and the shoe total as a sum of counts
    always_comb begin
        query_hit   = 1'b0;
        lowest_rank = 4'd0;
        total       = 9'd0;
        for (int r = RANK_TEN; r >= RANK_ACE; r--) begin
            total = total + 9'(cnt[r]);
            if (cnt[r] != 8'd0) lowest_rank = 4'(r);
            if (query_rank == 4'(r) && cnt[r] != 8'd0) query_hit = 1'b1;
        end
    end
endmodule

// File: rtl/card_shoe_arbiter.sv
// card_shoe_arbiter: round-robin draw arbiter over a finite shoe fed by a free-running RNG
module card_shoe_arbiter
    import card_shoe_arbiter_pkg::*;
#(
    parameter int NUM_DECKS = 1,
    parameter int MAX_RETRY = 16
) (
    input logic                 clk,
    input logic                 rst,
    card_shoe_arbiter_if.slave  bus
);
    localparam int MW = $clog2(MAX_RETRY + 1);

    shoe_state_e   state;
    owner_e        owner, rr_last, grant;
    logic          pending, hit, last_try, take, refill;
    logic [MW-1:0] misses;
    logic [3:0]    lowest, pick;
    logic [8:0]    total;

    assign last_try = misses == MW'(MAX_RETRY - 1);
    assign take     = state == S_SAMPLE && (hit || last_try);
    assign pick     = hit ? bus.rng_value : lowest;
    assign refill   = state == S_IDLE && (bus.shuffle || pending);
    assign grant    = (bus.p_req && bus.d_req) ? (rr_last == OWN_DEALER ? OWN_PLAYER : OWN_DEALER)
                    : (bus.p_req ? OWN_PLAYER : OWN_DEALER);

    assign bus.cards_left = total;
    assign bus.shoe_empty = total == 9'd0;
    assign bus.busy       = state != S_IDLE;

    card_shoe_arbiter_rank_pool #(.NUM_DECKS(NUM_DECKS)) u_pool (
        .clk        (clk),
        .rst        (rst),
        .refill     (refill),
        .dec        (take),
        .dec_rank   (pick),
        .query_rank (bus.rng_value),
        .query_hit  (hit),
        .lowest_rank(lowest),
        .total      (total)
    );

    // shoe FSM: apply shuffles, arbitrate, sample the RNG until a hit or fallback, pulse the ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            owner        <= OWN_PLAYER;
            rr_last      <= OWN_DEALER;
            pending      <= 1'b0;
            misses       <= '0;
            bus.p_ack    <= 1'b0;
            bus.d_ack    <= 1'b0;
            bus.card_out <= 4'd0;
        end else begin
            bus.p_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.shuffle || pending) begin
                        pending <= 1'b0;
                    end else if ((bus.p_req || bus.d_req) && !bus.shoe_empty) begin
                        owner   <= grant;
                        rr_last <= grant;
                        misses  <= '0;
                        state   <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (bus.shuffle) pending <= 1'b1;
                    if (take) begin
                        bus.card_out <= pick;
                        bus.p_ack    <= owner == OWN_PLAYER;
                        bus.d_ack    <= owner == OWN_DEALER;
                        state        <= S_DELIVER;
                    end else begin
                        misses <= misses + MW'(1);
                    end
                end
                default: begin
                    if (bus.shuffle) pending <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_card_shoe_arbiter.sv
// tb_card_shoe_arbiter: directed scenarios plus randomized traffic checked against a shoe model
module tb_card_shoe_arbiter;
    localparam int ND = 1;
    localparam int MR = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rng_rand = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    card_shoe_arbiter_if bus();
    card_shoe_arbiter #(.NUM_DECKS(ND), .MAX_RETRY(MR)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // model: shoe contents as a rank array, draw progress as a phase (0 idle, 1 drawing, 2 handing over)
    int m_cnt [1:10];
    int m_phase = 0, m_who = 0, m_rr = 1, m_tries = 0, m_card = 0;
    bit m_pend = 1'b0, m_valid = 1'b0;

    function automatic int m_left();
        int s = 0;
        for (int r = 1; r <= 10; r++) s += m_cnt[r];
        return s;
    endfunction

    function automatic void m_refill();
        for (int r = 1; r <= 10; r++) m_cnt[r] = (r == 10 ? 16 : 4) * ND;
    endfunction

    always @(posedge clk) begin
        int pick, rv;
        if (rst) begin
            m_refill();
            m_phase = 0; m_rr = 1; m_pend = 1'b0; m_card = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            pick = 0;
            rv = int'(bus.rng_value);
            if (m_phase == 0) begin
                if (bus.shuffle || m_pend) begin
                    m_refill();
                    m_pend = 1'b0;
                end else if ((bus.p_req || bus.d_req) && m_left() > 0) begin
                    m_who = (bus.p_req && bus.d_req) ? 1 - m_rr : (bus.p_req ? 0 : 1);
                    m_rr = m_who;
                    m_tries = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (bus.shuffle) m_pend = 1'b1;
                if (rv >= 1 && rv <= 10 && m_cnt[rv] > 0) pick = rv;
                else begin
                    m_tries++;
                    if (m_tries == MR)
                        for (int r = 10; r >= 1; r--) if (m_cnt[r] > 0) pick = r;
                end
                if (pick != 0) begin
                    m_cnt[pick]--;
                    m_card = pick;
                    m_phase = 2;
                end
            end else begin
                if (bus.shuffle) m_pend = 1'b1;
                m_phase = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison of every output and every rank count against the model
    always @(posedge clk) begin
        int s;
        #2;
        if (m_valid) begin
            chk("p_ack", int'(bus.p_ack), int'(m_phase == 2 && m_who == 0));
            chk("d_ack", int'(bus.d_ack), int'(m_phase == 2 && m_who == 1));
            chk("ack_onehot", int'(bus.p_ack & bus.d_ack), 0);
            chk("card_out", int'(bus.card_out), m_card);
            chk("cards_left", int'(bus.cards_left), m_left());
            chk("shoe_empty", int'(bus.shoe_empty), int'(m_left() == 0));
            chk("busy", int'(bus.busy), int'(m_phase != 0));
            s = 0;
            for (int r = 1; r <= 10; r++) begin
                chk($sformatf("rank%0d_count", r), int'(dut.u_pool.cnt[r]), m_cnt[r]);
                s += int'(dut.u_pool.cnt[r]);
            end
            chk("count_sum", s, int'(bus.cards_left));
        end
    end

    task automatic nedge();
        @(negedge clk);
        if (rng_rand) bus.rng_value = 4'($urandom_range(0, 15));
    endtask

    task automatic pedge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input bit side, input int limit, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < limit) begin
            pedge();
            cyc++;
            got = side ? bus.d_ack : bus.p_ack;
            if (!got && cyc < limit) nedge();
        end
        chk("ack_within_bound", int'(got), 1);
    endtask

    task automatic draw(input bit side, output int cyc);
        nedge();
        if (side) bus.d_req = 1'b1; else bus.p_req = 1'b1;
        wait_ack(side, 40, cyc);
        nedge();
        if (side) bus.d_req = 1'b0; else bus.p_req = 1'b0;
    endtask

    task automatic reset_dut();
        nedge();
        rst = 1'b1;
        bus.p_req = 1'b0;
        bus.d_req = 1'b0;
        bus.shuffle = 1'b0;
        pedge();
        nedge();
        rst = 1'b0;
    endtask

    initial begin
        int cyc, got_ack;
        bus.p_req = 1'b0;
        bus.d_req = 1'b0;
        bus.shuffle = 1'b0;
        bus.rng_value = 4'd0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_left", int'(bus.cards_left), 52);
        chk("reset_card", int'(bus.card_out), 0);

        // T1: single player draw with an immediate hit on rank 7
        rng_rand = 1'b0;
        nedge();
        rst = 1'b0;
        bus.rng_value = 4'd7;
        bus.p_req = 1'b1;
        wait_ack(1'b0, 40, cyc);
        chk("t1_latency", cyc, 2);
        chk("t1_card", int'(bus.card_out), 7);
        chk("t1_left", int'(bus.cards_left), 51);
        chk("t1_rank7", int'(dut.u_pool.cnt[7]), 3);
        nedge();
        bus.p_req = 1'b0;

        // T2: both requests held high, grants alternate starting with the player
        reset_dut();
        rng_rand = 1'b1;
        bus.p_req = 1'b1;
        bus.d_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            got_ack = 0;
            while (got_ack == 0 && cyc < 40) begin
                pedge();
                cyc++;
                got_ack = int'(bus.p_ack || bus.d_ack);
                if (got_ack == 0) nedge();
            end
            chk("t2_acked", got_ack, 1);
            chk($sformatf("t2_grant%0d_is_dealer", i), int'(bus.d_ack), i % 2);
            nedge();
        end
        bus.p_req = 1'b0;
        bus.d_req = 1'b0;

        // T3: empty rank 5, then hold rng at 5 until the fallback picks the ace
        reset_dut();
        rng_rand = 1'b0;
        bus.rng_value = 4'd5;
        for (int i = 0; i < 4; i++) draw(1'b0, cyc);
        chk("t3_rank5_empty", int'(dut.u_pool.cnt[5]), 0);
        nedge();
        bus.p_req = 1'b1;
        wait_ack(1'b0, 40, cyc);
        chk("t3_latency", cyc, 17);
        chk("t3_card", int'(bus.card_out), 1);
        chk("t3_left", int'(bus.cards_left), 47);
        nedge();
        bus.p_req = 1'b0;

        // T4: drain the shoe, starve a request, then shuffle and serve it
        reset_dut();
        rng_rand = 1'b1;
        for (int i = 0; i < 52; i++) draw(1'b0, cyc);
        pedge();
        chk("t4_empty", int'(bus.shoe_empty), 1);
        chk("t4_left0", int'(bus.cards_left), 0);
        nedge();
        bus.p_req = 1'b1;
        got_ack = 0;
        for (int i = 0; i < 20; i++) begin
            pedge();
            if (bus.p_ack) got_ack++;
            nedge();
        end
        chk("t4_no_ack_when_empty", got_ack, 0);
        bus.shuffle = 1'b1;
        pedge();
        chk("t4_refill", int'(bus.cards_left), 52);
        chk("t4_shuffle_before_grant", int'(bus.busy), 0);
        nedge();
        bus.shuffle = 1'b0;
        wait_ack(1'b0, 40, cyc);
        chk("t4_left_after", int'(bus.cards_left), 51);
        nedge();
        bus.p_req = 1'b0;

        // T5: shuffle during sampling waits until the in-flight card is delivered
        reset_dut();
        rng_rand = 1'b0;
        bus.rng_value = 4'd15;
        bus.p_req = 1'b1;
        pedge();
        chk("t5_busy", int'(bus.busy), 1);
        nedge();
        bus.shuffle = 1'b1;
        pedge();
        nedge();
        bus.shuffle = 1'b0;
        bus.rng_value = 4'd3;
        pedge();
        chk("t5_ack", int'(bus.p_ack), 1);
        chk("t5_card", int'(bus.card_out), 3);
        chk("t5_left", int'(bus.cards_left), 51);
        chk("t5_rank3", int'(dut.u_pool.cnt[3]), 3);
        nedge();
        bus.p_req = 1'b0;
        pedge();
        nedge();
        bus.d_req = 1'b1;
        pedge();
        chk("t5_refill", int'(bus.cards_left), 52);
        chk("t5_no_grant_on_refill", int'(bus.busy), 0);
        nedge();
        wait_ack(1'b1, 40, cyc);
        nedge();
        bus.d_req = 1'b0;

        // T6: reset in the middle of a draw aborts it and refills the shoe
        reset_dut();
        bus.rng_value = 4'd2;
        draw(1'b0, cyc);
        nedge();
        bus.rng_value = 4'd0;
        bus.p_req = 1'b1;
        pedge();
        pedge();
        chk("t6_busy", int'(bus.busy), 1);
        chk("t6_left_before", int'(bus.cards_left), 51);
        nedge();
        rst = 1'b1;
        pedge();
        chk("t6_idle", int'(bus.busy), 0);
        chk("t6_left", int'(bus.cards_left), 52);
        chk("t6_no_ack", int'(bus.p_ack), 0);
        nedge();
        rst = 1'b0;
        bus.p_req = 1'b0;

        // randomized traffic: requesters hold until ack, occasional drops, shuffles and resets
        rng_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            nedge();
            if (bus.p_ack) bus.p_req = 1'b0;
            else if (!bus.p_req) bus.p_req = $urandom_range(0, 2) == 0;
            else if (bus.busy && $urandom_range(0, 49) == 0) bus.p_req = 1'b0;
            if (bus.d_ack) bus.d_req = 1'b0;
            else if (!bus.d_req) bus.d_req = $urandom_range(0, 2) == 0;
            else if (bus.busy && $urandom_range(0, 49) == 0) bus.d_req = 1'b0;
            bus.shuffle = $urandom_range(0, 59) == 0;
            rst = $urandom_range(0, 399) == 0;
        end
        nedge();
        rst = 1'b0;
        bus.p_req = 1'b0;
        bus.d_req = 1'b0;
        bus.shuffle = 1'b0;
        pedge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
